// File: rtl/mem_access_unit_if.sv
// Control-side request/response and memory-bus signals of the memory access unit.
// The unit is the slave of this bundle; control logic and the bus agent sit on the master side.
interface mem_access_unit_if;
  logic        mem_rd;
  logic        mem_wr;
  logic        ir_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        clk_en;
  logic [31:0] instr;
  logic [31:0] mdr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        timeout_err;
  logic        align_err;
  logic [31:0] stall_cnt;

  // Bus handshake: a transfer is offered while bus_req=1 with bus_we/bus_addr/bus_wdata
  // held stable; it completes in the cycle bus_ack=1. bus_ack outside a request is ignored.
  modport slave (
    input  mem_rd, mem_wr, ir_write, addr, wdata, bus_ack, bus_rdata,
    output clk_en, instr, mdr, bus_req, bus_we, bus_addr, bus_wdata,
           timeout_err, align_err, stall_cnt
  );

  modport master (
    output mem_rd, mem_wr, ir_write, addr, wdata, bus_ack, bus_rdata,
    input  clk_en, instr, mdr, bus_req, bus_we, bus_addr, bus_wdata,
           timeout_err, align_err, stall_cnt
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle-CPU memory access unit: stalls the datapath via clk_en while a single
// bus transaction (fetch, load or store) runs, with alignment and timeout protection.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q;
  logic [CW-1:0] tcnt_q;
  logic          irw_q;
  logic          bus_req_q;
  logic          bus_we_q;
  logic [31:0]   bus_addr_q;
  logic [31:0]   bus_wdata_q;
  logic [31:0]   instr_q;
  logic [31:0]   mdr_q;
  logic          terr_q;
  logic          aerr_q;
  logic [31:0]   stall_q;
  logic          req;
  logic          clk_en;

  assign req = bus.mem_rd | bus.mem_wr;

  // clk_en is combinational so the control FSM freezes in the very cycle it asks.
  always_comb begin
    clk_en = 1'b0;
    case (state_q)
      IDLE:    clk_en = ~req;
      DONE:    clk_en = 1'b1;
      default: clk_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      irw_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      instr_q     <= '0;
      mdr_q       <= '0;
      terr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (!clk_en && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (bus.addr[1:0] != 2'b00) begin
              // Misaligned: skip the bus entirely; reads return zero.
              aerr_q <= 1'b1;
              if (!bus.mem_wr) begin
                if (bus.ir_write) instr_q <= '0;
                else              mdr_q   <= '0;
              end
              state_q <= DONE;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= bus.mem_wr;
              bus_addr_q  <= bus.addr;
              bus_wdata_q <= bus.wdata;
              irw_q       <= bus.ir_write;
              tcnt_q      <= '0;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            if (!bus_we_q) begin
              if (irw_q) instr_q <= bus.bus_rdata;
              else       mdr_q   <= bus.bus_rdata;
            end
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            state_q   <= DONE;
          end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
            terr_q <= 1'b1;
            if (!bus_we_q) begin
              if (irw_q) instr_q <= '0;
              else       mdr_q   <= '0;
            end
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            state_q   <= DONE;
          end else begin
            tcnt_q <= tcnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.clk_en      = clk_en;
  assign bus.instr       = instr_q;
  assign bus.mdr         = mdr_q;
  assign bus.bus_req     = bus_req_q;
  assign bus.bus_we      = bus_we_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_wdata   = bus_wdata_q;
  assign bus.timeout_err = terr_q;
  assign bus.align_err   = aerr_q;
  assign bus.stall_cnt   = stall_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: transaction-level reference model feeding an
// expected queue, drained by a monitor that checks each completed access.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        terr;
    logic        aerr;
    logic [31:0] stall;
    logic [7:0]  nbus;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  mem_access_unit_if ifc();

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc.slave),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [31:0] m_instr, m_mdr, m_stall;
  logic        m_terr, m_aerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input logic rd, input logic wr, input logic irw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] rdata);
    exp_t        e;
    logic [31:0] tgt;
    int          nst, nb, k;
    bit          fin;
    longint      sum;
    // Reference model: outcome of one access from the unit's rules.
    if (a[1:0] != 2'b00) begin
      m_aerr = 1'b1; tgt = '0; nst = 1; nb = 0;
    end else if (ack_dly >= 1 && ack_dly <= TIMEOUT) begin
      tgt = rdata; nst = 1 + ack_dly; nb = ack_dly;
    end else begin
      m_terr = 1'b1; tgt = '0; nst = 1 + TIMEOUT; nb = TIMEOUT;
    end
    if (!wr) begin
      if (irw) m_instr = tgt;
      else     m_mdr   = tgt;
    end
    sum = longint'(m_stall) + longint'(nst);
    m_stall = (sum > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
    e.instr = m_instr; e.mdr = m_mdr; e.terr = m_terr; e.aerr = m_aerr;
    e.stall = m_stall; e.nbus = 8'(nb);
    exp_q.push_back(W'(e));

    @(posedge clk); #1;
    ifc.mem_rd = rd; ifc.mem_wr = wr; ifc.ir_write = irw; ifc.addr = a; ifc.wdata = wd;
    k = 0; fin = 1'b0;
    for (int c = 0; c < TIMEOUT + 4; c++) begin
      @(posedge clk); #1;
      if (ifc.clk_en) begin
        fin = 1'b1;
        break;
      end
      if (ifc.bus_req) begin
        k++;
        check("bus_we", {31'd0, ifc.bus_we}, {31'd0, wr});
        check("bus_addr", ifc.bus_addr, a);
        if (wr) check("bus_wdata", ifc.bus_wdata, wd);
        ifc.bus_ack   = (k == ack_dly);
        ifc.bus_rdata = (k == ack_dly) ? rdata : $urandom;
      end else begin
        ifc.bus_ack = 1'b0;
      end
    end
    ifc.mem_rd = 1'b0; ifc.mem_wr = 1'b0; ifc.ir_write = 1'b0; ifc.bus_ack = 1'b0;
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL txn_end: clk_en never returned high for addr %h", a);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_ce = 1'b1;
  int   nbus    = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      nbus    = 0;
      prev_ce = ifc.clk_en;
    end else begin
      if (ifc.bus_req) nbus++;
      if (ifc.clk_en && !prev_ce) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pop_empty: completion seen with no expected entry at %0t", $time);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("instr", ifc.instr, e.instr);
          check("mdr", ifc.mdr, e.mdr);
          check("timeout_err", {31'd0, ifc.timeout_err}, {31'd0, e.terr});
          check("align_err", {31'd0, ifc.align_err}, {31'd0, e.aerr});
          check("stall_cnt", ifc.stall_cnt, e.stall);
          check("bus_req_cycles", 32'(nbus), {24'd0, e.nbus});
        end
        nbus = 0;
      end
      prev_ce = ifc.clk_en;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, rd_v, wd_v;
    int op, dly;
    logic r, w, irw;

    rst = 1'b1;
    ifc.mem_rd = 1'b0; ifc.mem_wr = 1'b0; ifc.ir_write = 1'b0;
    ifc.addr = '0; ifc.wdata = '0; ifc.bus_ack = 1'b0; ifc.bus_rdata = '0;
    m_instr = '0; m_mdr = '0; m_stall = '0; m_terr = 1'b0; m_aerr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_instr", ifc.instr, 32'h0);
    check("rst_mdr", ifc.mdr, 32'h0);
    check("rst_bus_req", {31'd0, ifc.bus_req}, 32'h0);
    check("rst_stall_cnt", ifc.stall_cnt, 32'h0);
    check("rst_errs", {30'd0, ifc.timeout_err, ifc.align_err}, 32'h0);
    check("rst_clk_en", {31'd0, ifc.clk_en}, 32'h1);
    mon_en = 1'b1;

    // Directed cases
    do_txn(1, 0, 1, 32'h0000_0040, 32'h0, 1, 32'h2008_0005);   // fetch, ack first cycle
    do_txn(1, 0, 0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);   // load, ack after 3
    do_txn(0, 1, 0, 32'h0000_0200, 32'h1234_5678, 2, 32'hFFFF_0000); // store
    do_txn(1, 0, 0, 32'h0000_0104, 32'h0, 0, 32'h0);           // load, timeout
    do_txn(1, 0, 0, 32'h0000_0108, 32'h0, 1, 32'hCAFE_F00D);   // error persists
    do_txn(1, 0, 0, 32'h0000_0102, 32'h0, 1, 32'h5555_AAAA);   // misaligned load
    do_txn(1, 0, 0, 32'h0000_0110, 32'h0, TIMEOUT, 32'h0BAD_CAFE); // ack on last allowed cycle

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op = $urandom_range(0, 3);
      r = (op != 2); w = (op >= 2);
      irw = (op == 0) ? 1'b1 : (op == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else                           a[1:0] = 2'b00;
      wd_v = $urandom; rd_v = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      do_txn(r, w, irw, a, wd_v, dly, rd_v);
    end

    // Reset in the middle of a bus transfer, then a stray ack in IDLE
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    @(posedge clk); #1;
    ifc.mem_rd = 1'b1; ifc.ir_write = 1'b0; ifc.addr = 32'h0000_0300;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_req", {31'd0, ifc.bus_req}, 32'h1);
    rst = 1'b1; ifc.mem_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_instr = '0; m_mdr = '0; m_stall = '0; m_terr = 1'b0; m_aerr = 1'b0;
    check("abort_bus_req", {31'd0, ifc.bus_req}, 32'h0);
    check("abort_instr", ifc.instr, 32'h0);
    check("abort_mdr", ifc.mdr, 32'h0);
    ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'h7777_8888;
    @(posedge clk); #1;
    ifc.bus_ack = 1'b0;
    @(posedge clk); #1;
    check("stray_ack_instr", ifc.instr, 32'h0);
    check("stray_ack_mdr", ifc.mdr, 32'h0);
    check("stray_ack_errs", {30'd0, ifc.timeout_err, ifc.align_err}, 32'h0);
    check("stray_ack_stall", ifc.stall_cnt, 32'h0);
    check("stray_ack_bus_req", {31'd0, ifc.bus_req}, 32'h0);
    mon_en = 1'b1;
    do_txn(1, 0, 0, 32'h0000_0400, 32'h0, 2, 32'h1357_9BDF);
    do_txn(0, 1, 0, 32'h0000_0401, 32'hABCD_0123, 1, 32'h0);   // misaligned store

    repeat (4) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles to wait for bus_ack before aborting.
REQ-002 SHALL have port clk  input  1  clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_rd  input  1  read request from control (fetch or load).
REQ-005 SHALL have port mem_wr  input  1  write request from control (store).
REQ-006 SHALL have port ir_write  input  1  read is an instruction fetch; data goes to instr, else to mdr.
REQ-007 SHALL have port addr  input  32  byte address (PC or ALUOut, already muxed by IorD).
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port clk_en  output  1  advance enable to control FSM and datapath state registers.
REQ-010 SHALL have port instr  output  32  instruction register.
REQ-011 SHALL have port mdr  output  32  memory data register.
REQ-012 SHALL have ports bus_req/bus_we  output  1 each  bus request and write qualifier.
REQ-013 SHALL have ports bus_addr/bus_wdata  output  32 each  registered bus address and write data.
REQ-014 SHALL have ports bus_ack  input  1  and  bus_rdata  input  32  bus completion and read data.
REQ-015 SHALL have ports timeout_err/align_err  output  1 each  sticky error flags.
REQ-016 SHALL have port stall_cnt  output  32  saturating count of cycles with clk_en=0.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE.
REQ-018 IDLE, no request: clk_en=1 (combinational), stay IDLE.
REQ-019 IDLE, request (mem_rd|mem_wr): clk_en=0 same cycle; latch addr, wdata, write flag, ir_write; go BUSY.
REQ-020 mem_rd and mem_wr both high SHALL be treated as write.
REQ-021 IDLE with addr[1:0]!=0 and request: no bus transaction, set align_err, load 32'h0 into the target register (reads only), go DONE.
REQ-022 BUSY: bus_req=1, bus_we=latched write flag, bus_addr/bus_wdata=latched values, clk_en=0, all stable until exit.
REQ-023 BUSY with bus_ack=1: reads capture bus_rdata into instr (ir_write latched) or mdr; writes capture nothing; go DONE.
REQ-024 BUSY without ack for TIMEOUT consecutive cycles: set timeout_err, load 32'h0 into target register (reads only), drop bus_req, go DONE.
REQ-025 DONE: clk_en=1, bus_req=0, request inputs ignored; next state IDLE unconditionally.
REQ-026 Minimum latency: request-to-clk_en=1 is 2 stall cycles (IDLE 0, BUSY 0, DONE 1) when ack arrives in first BUSY cycle.
REQ-027 bus_ack in IDLE or DONE SHALL be ignored (no register update, no error).
REQ-028 instr and mdr SHALL change only per REQ-021/023/024; they hold otherwise.
REQ-029 stall_cnt SHALL increment every cycle clk_en=0 and saturate at 32'hFFFF_FFFF.
REQ-030 timeout_err and align_err SHALL remain set until reset.

Reset
REQ-031 rst SHALL force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, instr=0, mdr=0, timeout_err=0, align_err=0, stall_cnt=0 on the next edge.
REQ-032 rst in BUSY SHALL abandon the transaction; bus_req low the cycle after reset; a later bus_ack ignored per REQ-027.
REQ-033 clk_en during rst cycle SHALL follow REQ-018/019 from current state; control FSM resets independently.

Verification
REQ-034 Fetch, ack in first BUSY cycle, addr=0x0000_0040, bus_rdata=0x2008_0005 -> clk_en 0,0,1; instr=0x2008_0005; mdr unchanged; stall_cnt=2.
REQ-035 Load, ack after 3 BUSY cycles, addr=0x0000_0100, bus_rdata=0xDEAD_BEEF -> mdr=0xDEAD_BEEF; instr unchanged; bus_req high exactly 3 cycles.
REQ-036 Store addr=0x0000_0200, wdata=0x1234_5678 -> bus_we=1, bus_wdata=0x1234_5678 held through ack; instr and mdr unchanged.
REQ-037 Load, no ack, TIMEOUT=16 -> bus_req high 16 cycles, then DONE; timeout_err=1; mdr=0; timeout_err persists across next good transaction.
REQ-038 Load addr=0x0000_0102 -> bus_req never asserted; align_err=1; mdr=0; clk_en 0,1.
REQ-039 rst mid-BUSY, then bus_ack pulsed in IDLE -> bus_req=0 after reset edge; instr/mdr=0; no error flags set.
